bl_zone_scheduler: RTL and testbench
====================================

Name: bl_zone_scheduler

Overview:
- Sequences the shared dimming-algorithm unit across all backlight zones of a frame.
- Takes one row of 8 block statistics from the input unit (row valid, V address, 192-bit pixel data) and issues one request per horizontal block to the algorithm unit over a req/ack handshake.
- Writes each returned duty into the zone-duty buffer at {V,H} and signals frame completion to the output unit.
- Watchdog substitutes full brightness if the algorithm unit stalls.

Parameters:
- H_BLOCKS, 8, horizontal zones per row; iPixelData is 24*H_BLOCKS bits.
- V_BLOCKS, 16, vertical zone rows; V address is 4 bits.
- DUTY_W, 8, duty width.
- TIMEOUT, 64, max cycles oALG_req may wait for iALG_ack.

Ports:
- iODCK  in  1  pixel clock, single clock domain.
- iRST  in  1  synchronous active-high reset.
- iVSYNC  in  1  frame sync, level; rising edge = new frame.
- iRowValid  in  1  one-cycle pulse: row statistics valid (input unit enable-output).
- iV_Address  in  4  zone row of the current iPixelData.
- iPixelData  in  192  block stats; block h = [24h+23:24h].
- oALG_req  out  1  request to algorithm unit.
- oALG_blk  out  24  block statistic presented with oALG_req.
- iALG_ack  in  1  algorithm result valid.
- iALG_duty  in  DUTY_W  result duty.
- oDutyWE  out  1  duty buffer write strobe.
- oDutyAddr  out  7  {V[3:0],H[2:0]}.
- oDutyData  out  DUTY_W  duty to write.
- oFrameDone  out  1  one-cycle pulse after the last zone (V=V_BLOCKS-1, H=H_BLOCKS-1) is written.
- oBusy  out  1  row in flight or pending.
- oOverrun  out  1  sticky: row dropped; cleared on iVSYNC rise.
- oALGTimeout  out  1  sticky: watchdog fired; cleared only by iRST.

Behaviour:
- Reset (synchronous, iRST=1 at an iODCK edge):
  - All outputs 0; FSM to IDLE; pending and working row buffers empty; H counter 0; watchdog 0.
  - Reset mid-handshake drops the request; any iALG_ack arriving after reset is ignored.
- Buffering: one working row (being processed) plus one pending row.
  - iRowValid with pending empty: capture data and V into pending.
  - iRowValid with pending full: drop the new row and set oOverrun. The pending row is kept.
  - If pending moves to working in the same cycle as a new iRowValid, the new row is accepted.
- FSM states: IDLE, REQ, WRITE, ROWEND.
- IDLE:
  - Pending full: move it to working, H=0, go to REQ next cycle.
  - Latency: iRowValid captured at edge t; oALG_req high in the cycle after edge t+1.
- REQ:
  - oALG_req=1; oALG_blk = working[24H+23:24H]. Both held stable until ack.
  - iALG_ack in REQ: latch iALG_duty, go to WRITE. Ack and req may coincide in the first REQ cycle.
  - iALG_ack outside REQ is ignored.
  - Watchdog counts REQ cycles. When it reaches TIMEOUT with no ack: latch duty = all ones (fail-safe full brightness), set oALGTimeout, go to WRITE.
- WRITE:
  - One cycle: oDutyWE=1, oDutyAddr={V,H}, oDutyData = latched duty.
  - If H<H_BLOCKS-1: H+1, back to REQ.
  - Otherwise go to ROWEND.
  - Minimum 2 cycles per block; a row takes at least 2*H_BLOCKS+1 cycles.
- ROWEND:
  - One cycle; if V=V_BLOCKS-1, pulse oFrameDone.
  - Then go to IDLE. A full pending buffer is taken on that IDLE cycle.
- oBusy = (state != IDLE) or pending full.
- iVSYNC rising edge (registered, edge detected internally):
  - Clears oOverrun.
  - Does not abort the working row or pending row; rows complete under their own V address.
- V address is taken from the row, not counted. Rows may arrive in any order; duplicate V overwrites the earlier duties.
- H counter is 3 bits with no wrap beyond H_BLOCKS-1. Watchdog saturates and resets on entering REQ.

Decomposition:
- Shared package bl_pkg:
  - H_BLOCKS, V_BLOCKS, DUTY_W, BLK_W=24.
  - FSM state encoding constants.
  - Fail-safe duty constant.
  - Duty address width 7.
- One natural sub-module: bl_row_buffer (pending/working two-entry row buffer with overrun detect). FSM and watchdog stay in the top.

Test Plan:
- Reset, one row V=3, blocks 0x000001..0x000008, ack every request one cycle after req, duty = 0x10+H -> eight oDutyWE at addresses 0x18..0x1F, data 0x10..0x17; oALG_req first high in the cycle after the capture edge; no oFrameDone.
- Row V=15 with ack same cycle as req -> writes at 0x78..0x7F, spaced 2 cycles apart; oFrameDone single pulse one cycle after the 0x7F write; oBusy low afterwards.
- Three iRowValid pulses 3 cycles apart while the first row is processing -> second row queued, third dropped; oOverrun=1; next iVSYNC rise clears oOverrun; the second row's writes still appear.
- Withhold iALG_ack on H=2 -> after 64 REQ cycles, write data 0xFF at {V,2}; oALGTimeout=1 and stays set; H=3..7 proceed normally.
- Assert iRST during REQ with H=4, then ack one cycle later -> no oDutyWE; all outputs 0; FSM IDLE; next row starts at H=0.
- iVSYNC rise mid-row V=7 -> row completes all 8 writes at 0x38..0x3F, no abort.

Source files
------------

// File: rtl/bl_pkg.sv
// Shared sizes, FSM encoding and fail-safe constants for the backlight zone scheduler.
package bl_pkg;
  localparam int H_BLOCKS    = 8;
  localparam int V_BLOCKS    = 16;
  localparam int DUTY_W      = 8;
  localparam int BLK_W       = 24;
  localparam int ROW_W       = BLK_W * H_BLOCKS;
  localparam int H_W         = 3;
  localparam int V_W         = 4;
  localparam int ADDR_W      = 7;
  localparam int ALG_TIMEOUT = 64;

  // A stalled algorithm unit must never leave a zone dark: fall back to full brightness.
  localparam logic [DUTY_W-1:0] FAILSAFE_DUTY = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WRITE  = 2'd2,
    ST_ROWEND = 2'd3
  } state_e;

  function automatic logic [ADDR_W-1:0] duty_addr(input logic [V_W-1:0] v,
                                                  input logic [H_W-1:0] h);
    return {v, h};
  endfunction
endpackage

// File: rtl/bl_row_buffer.sv
// Two-entry row store: a pending row waiting for the scheduler and the working row
// being sequenced. A row arriving while pending is occupied is dropped and flagged.
module bl_row_buffer
  import bl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             row_valid,
  input  logic [V_W-1:0]   v_addr,
  input  logic [ROW_W-1:0] row_data,
  input  logic             take,
  input  logic             clr_overrun,
  output logic             pend_full,
  output logic [ROW_W-1:0] work_data,
  output logic [V_W-1:0]   work_v,
  output logic             overrun
);

  logic             pend_vld_q, pend_vld_d;
  logic [ROW_W-1:0] pend_data_q, pend_data_d;
  logic [V_W-1:0]   pend_v_q, pend_v_d;
  logic [ROW_W-1:0] work_data_q, work_data_d;
  logic [V_W-1:0]   work_v_q, work_v_d;
  logic             overrun_q, overrun_d;
  logic             accept;

  // A slot freed by take in this same cycle can already receive the incoming row.
  assign accept = row_valid & (~pend_vld_q | take);

  always_comb begin
    pend_vld_d  = pend_vld_q;
    pend_data_d = pend_data_q;
    pend_v_d    = pend_v_q;
    work_data_d = work_data_q;
    work_v_d    = work_v_q;
    overrun_d   = overrun_q;
    if (take) begin
      work_data_d = pend_data_q;
      work_v_d    = pend_v_q;
      pend_vld_d  = 1'b0;
    end
    if (accept) begin
      pend_data_d = row_data;
      pend_v_d    = v_addr;
      pend_vld_d  = 1'b1;
    end
    if (clr_overrun) overrun_d = 1'b0;
    if (row_valid && !accept) overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_vld_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      pend_vld_q <= pend_vld_d;
      overrun_q  <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    pend_data_q <= pend_data_d;
    pend_v_q    <= pend_v_d;
    work_data_q <= work_data_d;
    work_v_q    <= work_v_d;
  end

  assign pend_full = pend_vld_q;
  assign work_data = work_data_q;
  assign work_v    = work_v_q;
  assign overrun   = overrun_q;

endmodule

// File: rtl/bl_zone_scheduler.sv
// Walks each buffered row block by block through the shared dimming unit and writes
// the returned duties into the zone buffer, with a fail-safe watchdog on the handshake.
module bl_zone_scheduler
  import bl_pkg::*;
#(
  parameter int TIMEOUT = ALG_TIMEOUT
) (
  input  logic              iODCK,
  input  logic              iRST,
  input  logic              iVSYNC,
  input  logic              iRowValid,
  input  logic [V_W-1:0]    iV_Address,
  input  logic [ROW_W-1:0]  iPixelData,
  output logic              oALG_req,
  output logic [BLK_W-1:0]  oALG_blk,
  input  logic              iALG_ack,
  input  logic [DUTY_W-1:0] iALG_duty,
  output logic              oDutyWE,
  output logic [ADDR_W-1:0] oDutyAddr,
  output logic [DUTY_W-1:0] oDutyData,
  output logic              oFrameDone,
  output logic              oBusy,
  output logic              oOverrun,
  output logic              oALGTimeout
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [H_W-1:0]  H_LAST  = H_W'(H_BLOCKS - 1);
  localparam logic [V_W-1:0]  V_LAST  = V_W'(V_BLOCKS - 1);

  state_e            state_q;
  logic [H_W-1:0]    h_q;
  logic [WD_W-1:0]   wd_q;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DUTY_W-1:0] data_q;
  logic              done_q;
  logic              timeout_q;
  logic              vsync_q, vsync_qq;

  logic              pend_full;
  logic [ROW_W-1:0]  work_data;
  logic [V_W-1:0]    work_v;
  logic              overrun;
  logic              take;
  logic              vsync_rise;

  function automatic logic [WD_W-1:0] wd_sat_inc(input logic [WD_W-1:0] c);
    return (c == WD_LAST) ? c : c + 1'b1;
  endfunction

  assign take       = (state_q == ST_IDLE) && pend_full;
  assign vsync_rise = vsync_q & ~vsync_qq;

  bl_row_buffer u_row_buffer (
    .clk         (iODCK),
    .rst         (iRST),
    .row_valid   (iRowValid),
    .v_addr      (iV_Address),
    .row_data    (iPixelData),
    .take        (take),
    .clr_overrun (vsync_rise),
    .pend_full   (pend_full),
    .work_data   (work_data),
    .work_v      (work_v),
    .overrun     (overrun)
  );

  always_ff @(posedge iODCK) begin
    if (iRST) begin
      state_q   <= ST_IDLE;
      h_q       <= '0;
      wd_q      <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      vsync_q   <= 1'b0;
      vsync_qq  <= 1'b0;
    end else begin
      vsync_q  <= iVSYNC;
      vsync_qq <= vsync_q;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pend_full) begin
            state_q <= ST_REQ;
            h_q     <= '0;
            wd_q    <= '0;
            req_q   <= 1'b1;
          end
        end
        ST_REQ: begin
          if (iALG_ack) begin
            state_q <= ST_WRITE;
            req_q   <= 1'b0;
            we_q    <= 1'b1;
            addr_q  <= duty_addr(work_v, h_q);
            data_q  <= iALG_duty;
          end else if (wd_q == WD_LAST) begin
            state_q   <= ST_WRITE;
            req_q     <= 1'b0;
            we_q      <= 1'b1;
            addr_q    <= duty_addr(work_v, h_q);
            data_q    <= FAILSAFE_DUTY;
            timeout_q <= 1'b1;
          end else begin
            wd_q <= wd_sat_inc(wd_q);
          end
        end
        ST_WRITE: begin
          if (h_q != H_LAST) begin
            state_q <= ST_REQ;
            h_q     <= h_q + 1'b1;
            wd_q    <= '0;
            req_q   <= 1'b1;
          end else begin
            state_q <= ST_ROWEND;
            done_q  <= (work_v == V_LAST);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // The block on the bus is selected by H from the working row, both frozen while requesting.
  assign oALG_req    = req_q;
  assign oALG_blk    = req_q ? work_data[h_q*BLK_W +: BLK_W] : '0;
  assign oDutyWE     = we_q;
  assign oDutyAddr   = addr_q;
  assign oDutyData   = data_q;
  assign oFrameDone  = done_q;
  assign oBusy       = (state_q != ST_IDLE) || pend_full;
  assign oOverrun    = overrun;
  assign oALGTimeout = timeout_q;

endmodule

// File: tb/tb_bl_zone_scheduler.sv
// Directed bench for bl_zone_scheduler: a responder model plays the algorithm unit and a
// scoreboard queue holds the duty writes each driven row should produce.
module tb_bl_zone_scheduler;
  import bl_pkg::*;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DUTY_W-1:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              vsync;
  logic              row_valid;
  logic [V_W-1:0]    v_addr;
  logic [ROW_W-1:0]  pix;
  logic              alg_req;
  logic [BLK_W-1:0]  alg_blk;
  logic              alg_ack;
  logic [DUTY_W-1:0] alg_duty;
  logic              duty_we;
  logic [ADDR_W-1:0] duty_addr_o;
  logic [DUTY_W-1:0] duty_data;
  logic              frame_done;
  logic              busy;
  logic              overrun;
  logic              alg_timeout;

  logic              resp_ack = 1'b0;
  logic [DUTY_W-1:0] resp_duty = '0;
  logic              force_ack = 1'b0;
  int                ack_delay = 1;
  logic [BLK_W-1:0]  stall_blk = 24'hFFFFFF;
  int                req_cnt = 0;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_we_cyc = 0;
  logic check_spacing = 1'b0;
  logic exp_done_next = 1'b0;

  assign alg_ack  = resp_ack | force_ack;
  assign alg_duty = force_ack ? 8'h55 : resp_duty;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  bl_zone_scheduler dut (
    .iODCK       (clk),
    .iRST        (rst),
    .iVSYNC      (vsync),
    .iRowValid   (row_valid),
    .iV_Address  (v_addr),
    .iPixelData  (pix),
    .oALG_req    (alg_req),
    .oALG_blk    (alg_blk),
    .iALG_ack    (alg_ack),
    .iALG_duty   (alg_duty),
    .oDutyWE     (duty_we),
    .oDutyAddr   (duty_addr_o),
    .oDutyData   (duty_data),
    .oFrameDone  (frame_done),
    .oBusy       (busy),
    .oOverrun    (overrun),
    .oALGTimeout (alg_timeout)
  );

  function automatic logic [DUTY_W-1:0] model_duty(input logic [BLK_W-1:0] blk);
    return blk[7:0] + 8'h0F;
  endfunction

  // Algorithm-unit model: acks ack_delay cycles into a request unless the block is stalled.
  always @(negedge clk) begin
    if (alg_req) begin
      if (req_cnt == ack_delay && alg_blk != stall_blk) begin
        resp_ack  = 1'b1;
        resp_duty = model_duty(alg_blk);
      end else begin
        resp_ack = 1'b0;
      end
      req_cnt++;
    end else begin
      resp_ack = 1'b0;
      req_cnt  = 0;
    end
  end

  // Output monitor: pops the scoreboard on every write, tracks spacing and frame-done.
  always @(negedge clk) begin
    exp_t e;
    if (frame_done || exp_done_next) begin
      tests++;
      assert (frame_done === exp_done_next) else begin
        fails++;
        $error("FAIL frame_done: got %0b want %0b", frame_done, exp_done_next);
      end
    end
    exp_done_next = duty_we && (duty_addr_o == 7'h7F);
    if (duty_we) begin
      tests++;
      if (sb.size() == 0) begin
        assert (1'b0) else begin
          fails++;
          $error("FAIL unexpected_write: got addr %h data %h want none", duty_addr_o, duty_data);
        end
      end else begin
        e = sb.pop_front();
        assert ({duty_addr_o, duty_data} === {e.addr, e.data}) else begin
          fails++;
          $error("FAIL duty_write: got addr %h data %h want addr %h data %h",
                 duty_addr_o, duty_data, e.addr, e.data);
        end
      end
      if (check_spacing && duty_addr_o[2:0] != 3'd0) begin
        tests++;
        assert (cyc - last_we_cyc == 2) else begin
          fails++;
          $error("FAIL write_spacing: got %0d cycles want 2", cyc - last_we_cyc);
        end
      end
      last_we_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic push_row(input logic [V_W-1:0] v, input logic [BLK_W-1:0] base,
                          input int stall_h, input int n);
    exp_t e;
    for (int h = 0; h < n; h++) begin
      e.addr = {v, h[2:0]};
      e.data = (h == stall_h) ? FAILSAFE_DUTY : model_duty(base + BLK_W'(h));
      sb.push_back(e);
    end
  endtask

  task automatic send_row(input logic [V_W-1:0] v, input logic [BLK_W-1:0] base);
    for (int h = 0; h < H_BLOCKS; h++) pix[h*BLK_W +: BLK_W] = base + BLK_W'(h);
    v_addr    = v;
    row_valid = 1'b1;
    @(negedge clk);
    row_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((busy || alg_req || sb.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    tests++;
    assert (n < budget) else begin
      fails++;
      $error("FAIL %s: idle not reached in %0d cycles, %0d writes outstanding",
             tag, budget, sb.size());
      sb.delete();
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst = 1'b1; vsync = 1'b0; row_valid = 1'b0; v_addr = '0; pix = '0;
    repeat (3) @(negedge clk);
    check("rst_req", {31'd0, alg_req}, 32'd0);
    check("rst_we", {31'd0, duty_we}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_flags", {30'd0, overrun, alg_timeout}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Row V=3, ack one cycle after request; first request one cycle after capture.
    ack_delay = 1;
    push_row(4'd3, 24'h000001, -1, 8);
    send_row(4'd3, 24'h000001);
    check("req_before_take", {31'd0, alg_req}, 32'd0);
    @(negedge clk);
    check("req_latency", {31'd0, alg_req}, 32'd1);
    check("first_blk", {8'd0, alg_blk}, 32'h000001);
    wait_idle("row_v3", 200);

    // Row V=15, same-cycle ack, back-to-back writes and frame done.
    ack_delay = 0;
    check_spacing = 1'b1;
    push_row(4'd15, 24'h0F0010, -1, 8);
    send_row(4'd15, 24'h0F0010);
    wait_idle("row_v15", 200);
    check_spacing = 1'b0;
    check("busy_after_frame", {31'd0, busy}, 32'd0);

    // Three rows 3 cycles apart: second queued, third dropped.
    ack_delay = 1;
    push_row(4'd1, 24'h000100, -1, 8);
    push_row(4'd2, 24'h000200, -1, 8);
    send_row(4'd1, 24'h000100);
    repeat (2) @(negedge clk);
    send_row(4'd2, 24'h000200);
    repeat (2) @(negedge clk);
    send_row(4'd4, 24'h000400);
    check("overrun_set", {31'd0, overrun}, 32'd1);
    check("busy_with_pending", {31'd0, busy}, 32'd1);
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    check("overrun_clr", {31'd0, overrun}, 32'd0);
    vsync = 1'b0;
    wait_idle("overrun_rows", 400);

    // Stall H=2: watchdog substitutes full brightness after 64 request cycles.
    check("timeout_clear", {31'd0, alg_timeout}, 32'd0);
    stall_blk = 24'h000502;
    push_row(4'd5, 24'h000500, 2, 8);
    send_row(4'd5, 24'h000500);
    wait_idle("timeout_row", 400);
    stall_blk = 24'hFFFFFF;
    check("timeout_set", {31'd0, alg_timeout}, 32'd1);

    // VSYNC rise mid-row does not abort it.
    ack_delay = 0;
    push_row(4'd7, 24'h000700, -1, 8);
    send_row(4'd7, 24'h000700);
    repeat (4) @(negedge clk);
    vsync = 1'b1;
    repeat (2) @(negedge clk);
    vsync = 1'b0;
    wait_idle("vsync_row", 200);
    check("timeout_sticky", {31'd0, alg_timeout}, 32'd1);

    // Reset while requesting H=4, then a late ack: nothing written.
    ack_delay = 1;
    stall_blk = 24'h000904;
    push_row(4'd9, 24'h000900, -1, 4);
    send_row(4'd9, 24'h000900);
    n = 0;
    while (!(alg_req && alg_blk == 24'h000904) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reached_h4", {31'd0, (n < 100)}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    force_ack = 1'b1;
    check("post_rst_req_blk", {7'd0, alg_req, alg_blk}, 32'd0);
    check("post_rst_write", {16'd0, duty_we, duty_addr_o, duty_data}, 32'd0);
    check("post_rst_flags", {28'd0, frame_done, busy, overrun, alg_timeout}, 32'd0);
    @(negedge clk);
    force_ack = 1'b0;
    check("late_ack_ignored", {29'd0, duty_we, busy, alg_req}, 32'd0);
    check("sb_drained_h0_3", sb.size(), 32'd0);
    stall_blk = 24'hFFFFFF;

    // Next row starts again from H=0.
    ack_delay = 0;
    push_row(4'd10, 24'h000A00, -1, 8);
    send_row(4'd10, 24'h000A00);
    wait_idle("row_after_rst", 200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got running want finished");
    $fatal(1, "bench timeout");
  end

endmodule
